// File: rtl/fma_ctrl_pkg.sv
// Shared sizing and scoreboard-entry type for the FMAC issue/bypass controller.
package fma_ctrl_pkg;

   localparam int unsigned REGW          = 5;
   localparam int unsigned LAT_DEF       = 4;
   localparam int unsigned BYP_STAGE_DEF = 3;

   // Bit positions inside the two-bit bypass select.
   localparam int unsigned SEL_X = 0;
   localparam int unsigned SEL_Z = 1;

   typedef struct packed {
      logic            valid;
      logic [REGW-1:0] rd;
   } sb_entry_t;

endpackage

// File: rtl/fma_src_hazard.sv
// Youngest-match hazard search for one source operand against stages 1..LAT-1.
module fma_src_hazard
   import fma_ctrl_pkg::*;
#(
   parameter int unsigned LAT       = LAT_DEF,
   parameter int unsigned BYP_STAGE = BYP_STAGE_DEF
) (
   input  logic                en,
   input  logic                byp_ok,
   input  logic [REGW-1:0]     src,
   input  sb_entry_t [LAT-2:0] sb,
   output logic                hazard_c,
   output logic                byp_c
);

   localparam int unsigned IW = $clog2(LAT - 1);

   logic found;

   // The consumer reads one cycle after issue, when the producer in stage s sits in s+1.
   always_comb begin
      hazard_c = 1'b0;
      byp_c    = 1'b0;
      found    = 1'b0;
      for (int unsigned s = 1; s < LAT; s++) begin
         if (!found && en && sb[IW'(s - 1)].valid && (sb[IW'(s - 1)].rd == src)) begin
            found = 1'b1;
            if (s + 1 == BYP_STAGE) begin
               byp_c    = byp_ok;
               hazard_c = !byp_ok;
            end else if (s + 1 != LAT) begin
               hazard_c = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fma_bypass_ctrl.sv
// FMAC issue/hazard controller: scoreboard shift register, bypass selects and
// register-file write-back control.
module fma_bypass_ctrl
   import fma_ctrl_pkg::*;
#(
   parameter int unsigned LAT       = LAT_DEF,
   parameter int unsigned BYP_STAGE = BYP_STAGE_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [REGW-1:0] issue_xa,
   input  logic [REGW-1:0] issue_ya,
   input  logic [REGW-1:0] issue_za,
   input  logic [2:0]      issue_src_v,
   input  logic [REGW-1:0] issue_rd,
   output logic [1:0]      bypsel,
   output logic            ex_valid,
   output logic [LAT-1:0]  stage_valid,
   output logic            rf_we,
   output logic [REGW-1:0] rf_waddr
);

   sb_entry_t [LAT-2:0] sb;   // stages 1..LAT-1; stage LAT lives in wb_valid/rf_waddr
   sb_entry_t           entry_in;
   logic                wb_valid;
   logic                haz_x, haz_y, haz_z;
   logic                byp_x, byp_z;
   logic                unused_byp_y;

   fma_src_hazard #(.LAT(LAT), .BYP_STAGE(BYP_STAGE)) u_haz_x (
      .en(issue_src_v[0]), .byp_ok(1'b1), .src(issue_xa), .sb(sb),
      .hazard_c(haz_x), .byp_c(byp_x)
   );

   // Y has no bypass path: any bypass-stage match stalls.
   fma_src_hazard #(.LAT(LAT), .BYP_STAGE(BYP_STAGE)) u_haz_y (
      .en(issue_src_v[1]), .byp_ok(1'b0), .src(issue_ya), .sb(sb),
      .hazard_c(haz_y), .byp_c(unused_byp_y)
   );

   fma_src_hazard #(.LAT(LAT), .BYP_STAGE(BYP_STAGE)) u_haz_z (
      .en(issue_src_v[2]), .byp_ok(1'b1), .src(issue_za), .sb(sb),
      .hazard_c(haz_z), .byp_c(byp_z)
   );

   assign issue_ready    = reset_n & issue_valid & ~(haz_x | haz_y | haz_z);
   assign entry_in.valid = issue_ready;
   assign entry_in.rd    = issue_rd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb       <= '0;
         wb_valid <= 1'b0;
         rf_waddr <= '0;
         bypsel   <= 2'b00;
      end else begin
         sb       <= {sb[LAT-3:0], entry_in};
         wb_valid <= sb[LAT-2].valid;
         if (sb[LAT-2].valid) begin
            rf_waddr <= sb[LAT-2].rd;
         end
         bypsel        <= 2'b00;
         if (issue_ready) begin
            bypsel[SEL_X] <= byp_x;
            bypsel[SEL_Z] <= byp_z;
         end
      end
   end

   for (genvar g = 0; g < LAT - 1; g++) begin : g_sv
      assign stage_valid[g] = sb[g].valid;
   end
   assign stage_valid[LAT-1] = wb_valid;

   assign ex_valid = sb[0].valid;
   assign rf_we    = wb_valid;

endmodule

// File: tb/tb_fma_bypass_ctrl.sv
// Bench for fma_bypass_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an in-flight-op list model.
module tb_fma_bypass_ctrl;

   localparam int LAT = 4;
   localparam int BYP = 3;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           issue_valid = 1'b0;
   logic           issue_ready;
   logic [4:0]     issue_xa = '0, issue_ya = '0, issue_za = '0, issue_rd = '0;
   logic [2:0]     issue_src_v = '0;
   logic [1:0]     bypsel;
   logic           ex_valid;
   logic [LAT-1:0] stage_valid;
   logic           rf_we;
   logic [4:0]     rf_waddr;

   fma_bypass_ctrl #(.LAT(LAT), .BYP_STAGE(BYP)) dut (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_xa(issue_xa), .issue_ya(issue_ya), .issue_za(issue_za),
      .issue_src_v(issue_src_v), .issue_rd(issue_rd), .bypsel(bypsel),
      .ex_valid(ex_valid), .stage_valid(stage_valid), .rf_we(rf_we), .rf_waddr(rf_waddr)
   );

   always #5 clk = ~clk;

   // Model: each accepted op remembers the cycle it was accepted in; its stage is its age.
   typedef struct {
      int         cyc;
      logic [4:0] rd;
      logic [1:0] sel;
   } op_t;

   op_t        q[$];
   int         now = 0;
   bit         acc = 1'b0;
   logic [4:0] acc_rd;
   logic [1:0] acc_sel;
   logic [4:0] last_wa = '0;
   int         n_tests = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, now);
      end
   endtask

   // A source is available when its youngest in-flight producer, one stage further on
   // at read time, is writing the RF (write-through) or sits at a usable bypass point.
   function automatic void src_eval(input logic en, input logic [4:0] r, input bit path,
                                    output bit haz, output bit byp);
      haz = 1'b0;
      byp = 1'b0;
      if (!en) return;
      for (int i = q.size() - 1; i >= 0; i--) begin
         int age;
         int p;
         age = now - q[i].cyc;
         if (age >= 1 && age <= LAT - 1 && q[i].rd == r) begin
            p = age + 1;
            if (p == LAT) ;
            else if (p == BYP && path) byp = 1'b1;
            else haz = 1'b1;
            return;
         end
      end
   endfunction

   always @(negedge clk) begin
      logic [LAT-1:0] e_sv;
      logic [1:0]     e_bs;
      logic           e_we;
      bit             hx, bx, hy, by, hz, bz, e_rdy;
      if (!reset_n) begin
         q.delete();
         last_wa = '0;
      end
      while (q.size() > 0 && now - q[0].cyc > LAT) void'(q.pop_front());
      e_sv = '0;
      e_bs = 2'b00;
      e_we = 1'b0;
      foreach (q[i]) begin
         int age;
         age = now - q[i].cyc;
         e_sv[age-1] = 1'b1;
         if (age == 1) e_bs = q[i].sel;
         if (age == LAT) begin
            e_we    = 1'b1;
            last_wa = q[i].rd;
         end
      end
      src_eval(issue_src_v[0], issue_xa, 1'b1, hx, bx);
      src_eval(issue_src_v[1], issue_ya, 1'b0, hy, by);
      src_eval(issue_src_v[2], issue_za, 1'b1, hz, bz);
      e_rdy   = reset_n && issue_valid && !(hx || hy || hz);
      acc     = e_rdy;
      acc_rd  = issue_rd;
      acc_sel = {bz, bx};
      check("m_issue_ready", 32'(issue_ready), 32'(e_rdy));
      check("m_stage_valid", 32'(stage_valid), 32'(e_sv));
      check("m_ex_valid", 32'(ex_valid), 32'(e_sv[0]));
      check("m_bypsel", 32'(bypsel), 32'(e_bs));
      check("m_rf_we", 32'(rf_we), 32'(e_we));
      check("m_rf_waddr", 32'(rf_waddr), 32'(last_wa));
   end

   always @(posedge clk) begin
      if (acc) q.push_back('{cyc: now, rd: acc_rd, sel: acc_sel});
      acc = 1'b0;
      now++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] rd, input logic [4:0] xa, input logic [4:0] ya,
                         input logic [4:0] za, input logic [2:0] sv);
      issue_valid = 1'b1;
      issue_rd    = rd;
      issue_xa    = xa;
      issue_ya    = ya;
      issue_za    = za;
      issue_src_v = sv;
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      repeat (n) cyc();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stage_valid", 32'(stage_valid), 0);
      check("reset_ready", 32'(issue_ready), 0);
      cyc();
      reset_n = 1'b1;

      // Independent back-to-back ops
      idle(LAT + 1);
      set_op(5'd1, 5'd2, 5'd3, 5'd4, 3'b111);
      @(negedge clk); check("indep_a_ready", 32'(issue_ready), 1);
      cyc();
      set_op(5'd5, 5'd6, 5'd7, 5'd8, 3'b111);
      @(negedge clk); check("indep_b_ready", 32'(issue_ready), 1);
      check("indep_bypsel", 32'(bypsel), 0);
      cyc();
      issue_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk); check("indep_we_r1", 32'(rf_we), 1); check("indep_wa_r1", 32'(rf_waddr), 1);
      cyc();
      @(negedge clk); check("indep_wa_r5", 32'(rf_waddr), 5);
      cyc();
      @(negedge clk); check("indep_we_off", 32'(rf_we), 0); check("indep_wa_hold", 32'(rf_waddr), 5);

      // X consumer right behind producer: one stall, then bypass
      idle(LAT + 1);
      set_op(5'd1, 5'd2, 5'd0, 5'd0, 3'b001);
      cyc();
      set_op(5'd10, 5'd1, 5'd0, 5'd0, 3'b001);
      @(negedge clk); check("x_stall", 32'(issue_ready), 0);
      cyc();
      @(negedge clk); check("x_issue", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("x_bypsel", 32'(bypsel), 32'h1);
      check("x_stage_valid", 32'(stage_valid), 32'h5);

      // Z consumer two cycles later: bypass without stall
      idle(LAT + 1);
      set_op(5'd1, 5'd2, 5'd0, 5'd0, 3'b001);
      cyc(); idle(1);
      set_op(5'd11, 5'd0, 5'd0, 5'd1, 3'b100);
      @(negedge clk); check("z_ready", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("z_bypsel", 32'(bypsel), 32'h2);

      // Same timing on Y: stall until RF write-through covers it
      idle(LAT + 1);
      set_op(5'd1, 5'd2, 5'd0, 5'd0, 3'b001);
      cyc(); idle(1);
      set_op(5'd12, 5'd0, 5'd1, 5'd0, 3'b010);
      @(negedge clk); check("y_stall", 32'(issue_ready), 0);
      cyc();
      @(negedge clk); check("y_issue", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("y_bypsel", 32'(bypsel), 0); check("y_ex_valid", 32'(ex_valid), 1);

      // Two producers of r9: the younger one governs
      idle(LAT + 1);
      set_op(5'd9, 5'd0, 5'd0, 5'd0, 3'b000);
      cyc();
      set_op(5'd9, 5'd0, 5'd0, 5'd0, 3'b000);
      cyc();
      set_op(5'd13, 5'd9, 5'd0, 5'd0, 3'b001);
      @(negedge clk); check("young_stall", 32'(issue_ready), 0);
      cyc();
      @(negedge clk); check("young_issue", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("young_bypsel", 32'(bypsel), 32'h1);

      // X and Z both bypass from the same producer
      idle(LAT + 1);
      set_op(5'd4, 5'd0, 5'd0, 5'd0, 3'b000);
      cyc(); idle(1);
      set_op(5'd14, 5'd4, 5'd0, 5'd4, 3'b101);
      @(negedge clk); check("xz_ready", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("xz_bypsel", 32'(bypsel), 32'h3);

      // Disabled sources never stall
      idle(LAT + 1);
      set_op(5'd4, 5'd0, 5'd0, 5'd0, 3'b000);
      cyc();
      set_op(5'd15, 5'd4, 5'd4, 5'd4, 3'b000);
      @(negedge clk); check("nosrc_ready", 32'(issue_ready), 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("nosrc_bypsel", 32'(bypsel), 0);

      // Self-dependence on an empty pipeline
      idle(LAT + 1);
      set_op(5'd3, 5'd3, 5'd3, 5'd3, 3'b111);
      @(negedge clk); check("self_ready", 32'(issue_ready), 1);
      cyc();

      // Reset with ops in flight
      idle(LAT + 1);
      set_op(5'd20, 5'd0, 5'd0, 5'd0, 3'b000); cyc();
      set_op(5'd21, 5'd0, 5'd0, 5'd0, 3'b000); cyc();
      set_op(5'd22, 5'd0, 5'd0, 5'd0, 3'b000); cyc();
      issue_valid = 1'b0;
      @(negedge clk); check("rst_pre_sv", 32'(stage_valid), 32'h7);
      cyc();
      reset_n     = 1'b0;
      issue_valid = 1'b1;
      #1;
      check("rst_sv", 32'(stage_valid), 0);
      check("rst_we", 32'(rf_we), 0);
      check("rst_bypsel", 32'(bypsel), 0);
      check("rst_ready", 32'(issue_ready), 0);
      cyc();
      reset_n     = 1'b1;
      issue_valid = 1'b0;
      for (int i = 0; i < LAT + 1; i++) begin
         @(negedge clk); check("rst_no_wb", 32'(rf_we), 0);
         cyc();
      end

      // Randomized traffic over a small register set to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         reset_n = ($urandom_range(0, 199) != 0);
         if (!(issue_valid && !issue_ready && reset_n && $urandom_range(0, 1) == 1)) begin
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_xa    = 5'($urandom_range(0, 7));
            issue_ya    = 5'($urandom_range(0, 7));
            issue_za    = 5'($urandom_range(0, 7));
            issue_src_v = 3'($urandom);
         end
         cyc();
      end
      reset_n     = 1'b1;
      issue_valid = 1'b0;
      idle(LAT + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fma_bypass_ctrl.md
Name: fma_bypass_ctrl

Overview:
Issue and hazard controller for the FMAC pipeline. It tracks destination registers of in-flight FMA operations in a LAT-deep scoreboard shift register. For each new operation it either drives the X/Z prerounded-bypass selects (bypsel[0]=X, bypsel[1]=Z) feeding the bypass muxes, or stalls issue until the operand is available. It sits between the FP issue stage and the FMAC datapath, and also produces the register-file write-back control.

Parameters:
REGW, 5, register index width
LAT, 4, FMAC pipeline depth in stages (stage 1 = operand read, stage LAT = register-file write); 3 <= LAT <= 8
BYP_STAGE, 3, stage whose prerounded result drives wbypass; 2 <= BYP_STAGE < LAT

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  FMA op requesting issue
issue_ready  out  1  op accepted this cycle (combinational)
issue_xa  in  REGW  X source register
issue_ya  in  REGW  Y source register
issue_za  in  REGW  Z source register
issue_src_v  in  3  source-used flags {z,y,x}
issue_rd  in  REGW  destination register
bypsel  out  2  registered bypass selects for stage-1 op: [0]=X, [1]=Z
ex_valid  out  1  stage-1 op valid
stage_valid  out  LAT  per-stage valid vector (bit s-1 = stage s)
rf_we  out  1  register-file write enable (stage LAT)
rf_waddr  out  REGW  register-file write address

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- On reset: all stage valids, rd fields and bypsel clear to 0. ex_valid=0, rf_we=0, rf_waddr=0. issue_ready=0 while reset_n=0.
- Pipeline advance: every cycle, unconditionally. Stage s moves to s+1; stage LAT retires.
- Stage-1 load: on accept, stage 1 loads {1, issue_rd}; otherwise it loads a bubble (valid=0).
- Operand timing: an op accepted in cycle t reads X/Y/Z in cycle t+1. The register file is write-through, so a stage-LAT write is visible to a same-cycle read.
- Per-source hazard check (enabled sources only):
  - Find the youngest valid stage s in 1..LAT-1 whose rd equals the source register; stage LAT is ignored because its write is visible via write-through.
  - No match: source is clear, select 0.
  - s+1 == BYP_STAGE: X/Z is clear with select 1. Y is a hazard, since Y has no bypass path.
  - s+1 == LAT: clear, select 0 (register file).
  - Any other s: hazard.
- Youngest match governs. An older matching entry is never used when a younger one exists.
- Issue rule: issue_ready = reset_n & issue_valid & no hazard on any enabled source.
- bypsel register: on accept it captures the computed selects; otherwise it clears to 00. It is never nonzero while ex_valid=0.
- A disabled source never stalls and never selects bypass.
- Self-dependence: an op whose rd equals its own source checks only older entries, never itself.
- Write-back: rf_we = stage_valid[LAT-1]; rf_waddr = rd of stage LAT. rf_waddr holds its last value when rf_we=0.
- Stall retry: a stalled op simply re-presents. Its hazard resolves as the producer advances; no state is kept for the waiting op.
- Reset mid-operation: all in-flight ops are dropped immediately; there is no write-back for them.
- Worst-case stall (LAT=4, BYP_STAGE=3):
  - Y source with producer in stage 1: 2 stall cycles.
  - X source with producer in stage 1: 1 stall cycle.

Decomposition:
- Shared package fma_ctrl_pkg: REGW and stage-index localparams, and a scoreboard-entry typedef {valid, rd}.
- One sub-module, fma_src_hazard: per-source youngest-match search returning {hazard, bypsel_bit}. Instantiate three times (X, Y, Z); tie the Y instance's bypass-capable input to 0.

Test Plan:
- Independent ops, r1<-f(r2,r3,r4) then r5<-f(r6,r7,r8) back-to-back -> issue_ready=1 both cycles, bypsel=00, rf_we on r1 at cycle t+4 and r5 at cycle t+5.
- Producer rd=r1, next-cycle consumer X=r1 -> 1-cycle stall. Issue when the producer is in stage 2; bypsel=01 on the consumer's stage-1 cycle, aligned with the producer in stage 3.
- Producer rd=r1, consumer Z=r1 issued 2 cycles later -> no stall, bypsel=10. Same case with Y=r1 -> stall until the producer reaches stage 3, then issue with bypsel=00.
- Two producers to r9 (stage 2 older, stage 1 younger), consumer X=r9 -> stall, not bypass; bypass selected only after the younger producer reaches stage 2.
- Consumer X=Z=r4 with producer r4 in stage 2 -> bypsel=11. With issue_src_v=3'b000 and a hazardous rd match -> no stall.
- Assert reset_n low with 3 ops in flight -> stage_valid=0, rf_we=0, bypsel=00 immediately, with no write-back after release.
